dot_product_feeder: RTL and testbench

- Front-end sequencer that drives the fp16 multi-MLP dot-product stack input stream (a, b, first, last) and collects its result stream (sum, valid).
- Accepts a length command, then streams operand beats from an upstream valid/ready source, inserting zero beats when the source starves.
- Queues finished dot products in a result FIFO with a valid/ready output.
- Credit control guarantees the FIFO never overflows.

---
 rtl/dot_product_feeder.sv | 182 ++++++++++++++++++
 tb/tb_dot_product_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_feeder.sv
// Front-end sequencer for the fp16 multi-MLP dot-product stack, plus its result queue.
// The stack is fed (a, b, first, last) beats and its (sum, valid) results are queued here.

// Small first-word-fall-through FIFO, synchronous reset.
// Latency: a push is visible at the head one cycle later; a pop takes effect at the clock edge.
// Backpressure: the caller must push only when not full or when popping in the same cycle.
module dpf_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && pop_rdy;
  assign head_vld = !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// Sequences length commands and operand beats into the dot-product stack; queues its results.
// Latency: an accepted beat appears on o_a/o_b one cycle later; results fall through the FIFO one cycle after i_valid.
// Backpressure: commands stall while credits are exhausted; starved cycles emit zero beats; results wait on i_res_ready.
module dot_product_feeder #(
  parameter int K         = 4,
  parameter int B         = 2,
  parameter int FP        = 16,
  parameter int LEN_W     = 16,
  parameter int RES_DEPTH = 4,
  parameter int PIPE_LAT  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [LEN_W-1:0]    i_cmd_len,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [K*B*FP-1:0]   i_in_a,
  input  logic [K*B*FP-1:0]   i_in_b,
  output logic [K*B*FP-1:0]   o_a,
  output logic [K*B*FP-1:0]   o_b,
  output logic                o_first,
  output logic                o_last,
  input  logic [FP-1:0]       i_sum,
  input  logic                i_valid,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [FP-1:0]       o_res_sum,
  output logic                o_busy,
  output logic                o_overflow
);
  localparam int CW  = $clog2(RES_DEPTH + 1);
  localparam int DCW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {DRAIN, IDLE, STREAM} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DCW-1:0]   drain_cnt;
  logic [LEN_W-1:0] remaining;
  logic             first_pend;
  logic [CW-1:0]    credits;
  logic             cmd_acc;
  logic             beat_acc;
  logic             zero_beat;
  logic             res_push;
  logic             res_pop;
  logic             fifo_full;

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_in_ready  = 1'b0;
    case (state)
      DRAIN: begin
        if (drain_cnt == DCW'(PIPE_LAT - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        o_cmd_ready = (credits < CW'(RES_DEPTH));
        if (i_cmd_valid && o_cmd_ready && (i_cmd_len != '0)) state_nxt = STREAM;
      end
      STREAM: begin
        o_in_ready = 1'b1;
        if (i_in_valid && (remaining == LEN_W'(1))) state_nxt = IDLE;
      end
      default: state_nxt = DRAIN;
    endcase
  end

  assign cmd_acc   = i_cmd_valid && o_cmd_ready;
  assign beat_acc  = i_in_valid && o_in_ready;
  // An empty vector still needs one first+last beat so the stack emits a 0 result in order.
  assign zero_beat = cmd_acc && (i_cmd_len == '0);
  assign res_pop   = o_res_valid && i_res_ready;
  assign res_push  = i_valid && (state != DRAIN) && (!fifo_full || res_pop);
  assign o_busy    = (state != IDLE) || (credits != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= DRAIN;
      drain_cnt  <= '0;
      remaining  <= '0;
      first_pend <= 1'b0;
      credits    <= '0;
      o_a        <= '0;
      o_b        <= '0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      if (cmd_acc) begin
        remaining  <= i_cmd_len;
        first_pend <= 1'b1;
      end else if (beat_acc) begin
        remaining  <= remaining - 1'b1;
        first_pend <= 1'b0;
      end

      if (cmd_acc && !res_pop) begin
        credits <= credits + CW'(1);
      end else if (!cmd_acc && res_pop) begin
        credits <= credits - CW'(1);
      end

      o_a     <= beat_acc ? i_in_a : '0;
      o_b     <= beat_acc ? i_in_b : '0;
      o_first <= beat_acc ? first_pend : zero_beat;
      o_last  <= beat_acc ? (remaining == LEN_W'(1)) : zero_beat;

      if (i_valid && (state != DRAIN) && fifo_full && !res_pop) begin
        o_overflow <= 1'b1;
      end
    end
  end

  dpf_fifo #(
    .W     (FP),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push_vld (res_push),
    .push_dat (i_sum),
    .pop_rdy  (i_res_ready),
    .head_vld (o_res_valid),
    .head_dat (o_res_sum),
    .full     (fifo_full)
  );
endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: emulates the fp16 stack and checks beats, handshakes and results
// against a transaction-level model of commands, vectors and queued results.
module tb_dot_product_feeder;
  localparam int K = 4, B = 2, FP = 16, LEN_W = 16, RES_DEPTH = 4, PIPE_LAT = 16;
  localparam int DW = K * B * FP;
  localparam int LANES = K * B;
  localparam int SLAT = 6;

  typedef logic [259:0] chk_t;
  typedef logic [2*DW+1:0] beat_t;
  typedef struct {
    int          due;
    logic [15:0] sum;
  } pend_t;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic [LEN_W-1:0] i_cmd_len = '0;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [DW-1:0]    i_in_a = '0;
  logic [DW-1:0]    i_in_b = '0;
  logic [DW-1:0]    o_a;
  logic [DW-1:0]    o_b;
  logic             o_first;
  logic             o_last;
  logic [FP-1:0]    i_sum = '0;
  logic             i_valid = 1'b0;
  logic             o_res_valid;
  logic             i_res_ready = 1'b0;
  logic [FP-1:0]    o_res_sum;
  logic             o_busy;
  logic             o_overflow;

  always #5 i_clk = ~i_clk;

  dot_product_feeder #(
    .K(K), .B(B), .FP(FP), .LEN_W(LEN_W), .RES_DEPTH(RES_DEPTH), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_len(i_cmd_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_a(o_a), .o_b(o_b), .o_first(o_first), .o_last(o_last),
    .i_sum(i_sum), .i_valid(i_valid),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_sum(o_res_sum),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input chk_t got, input chk_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pending stimulus: command lengths, their expected results, and all their beats in order.
  int            cmd_len_q[$];
  logic [15:0]   cmd_exp_q[$];
  logic [DW-1:0] beat_a_q[$];
  logic [DW-1:0] beat_b_q[$];
  // Model of the feeder: accepted-but-unreturned results, FIFO contents, next-cycle beat.
  logic [15:0]   exp_res_q[$];
  logic [15:0]   fifo_m[$];
  beat_t         exp_beat_q[$];
  pend_t         pipe_q[$];

  int  cyc = 0, drain_cnt = 0, outstanding = 0, beats_left = 0, beat_idx = 0;
  bit  ovf_m = 1'b0;
  int  rst_cycles = 0, stall_pct = 0, rdy_pct = 100, hold_idx = -1, hold_cycles = 0;
  bit  spur = 1'b0;
  real acc = 0.0;
  bit  acc_act = 1'b0;
  logic [15:0] pal [6] = '{16'h0000, 16'h3C00, 16'h4000, 16'hBC00, 16'h3800, 16'hC000};

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    while (e > 15) begin m = m * 2.0; e--; end
    while (e < 15) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic       s;
    real        m;
    int         e;
    logic [4:0] ex;
    logic [9:0] fr;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    ex = 5'(e + 15);
    fr = 10'($rtoi((m - 1.0) * 1024.0));
    return {s, ex, fr};
  endfunction

  function automatic real dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    real s = 0.0;
    for (int l = 0; l < LANES; l++) s += h2r(a[l*FP +: FP]) * h2r(b[l*FP +: FP]);
    return s;
  endfunction

  task automatic add_cmd(input int len, input bit rnd, input logic [15:0] av, input logic [15:0] bv);
    real s = 0.0;
    logic [DW-1:0] a, b;
    for (int i = 0; i < len; i++) begin
      for (int l = 0; l < LANES; l++) begin
        a[l*FP +: FP] = rnd ? pal[$urandom_range(5)] : av;
        b[l*FP +: FP] = rnd ? pal[$urandom_range(5)] : bv;
      end
      s += dot(a, b);
      beat_a_q.push_back(a);
      beat_b_q.push_back(b);
    end
    cmd_len_q.push_back(len);
    cmd_exp_q.push_back(r2h(s));
  endtask

  // Emulated stack: accumulates first..last, returns the sum SLAT cycles after last.
  task automatic stack_step();
    beat_t e;
    real   d;
    pend_t p;
    if (exp_beat_q.size() > 0) begin
      e = exp_beat_q.pop_front();
      check("beat", chk_t'({o_first, o_last, o_a, o_b}), chk_t'(e));
    end
    d = dot(o_a, o_b);
    if (o_first) begin
      acc = d;
      acc_act = 1'b1;
    end else if (acc_act) begin
      acc += d;
    end
    if (o_last && acc_act) begin
      p.due = cyc + SLAT;
      p.sum = r2h(acc);
      pipe_q.push_back(p);
      acc_act = 1'b0;
    end
  endtask

  task automatic drive();
    bit held;
    i_reset = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    i_valid = 1'b0;
    i_sum = '0;
    if (spur) begin
      i_valid = 1'b1;
      i_sum = 16'h1234;
      spur = 1'b0;
    end else if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      i_valid = 1'b1;
      i_sum = pipe_q[0].sum;
      void'(pipe_q.pop_front());
    end
    i_cmd_valid = (cmd_len_q.size() > 0) && (beats_left == 0);
    i_cmd_len = (cmd_len_q.size() > 0) ? LEN_W'(cmd_len_q[0]) : LEN_W'($urandom);
    held = (beats_left > 0) && (beat_idx == hold_idx) && (hold_cycles > 0);
    if (beats_left > 0 && !held && $urandom_range(99) >= stall_pct) begin
      i_in_valid = 1'b1;
      i_in_a = beat_a_q[0];
      i_in_b = beat_b_q[0];
    end else begin
      if (held) hold_cycles--;
      i_in_valid = 1'b0;
      i_in_a = {$urandom, $urandom, $urandom, $urandom};
      i_in_b = {$urandom, $urandom, $urandom, $urandom};
    end
    i_res_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic observe();
    bit    drained, idle, pop, full;
    int    len;
    beat_t nb;
    nb = '0;
    if (i_reset) begin
      repeat (beats_left) begin
        void'(beat_a_q.pop_front());
        void'(beat_b_q.pop_front());
      end
      beats_left = 0;
      drain_cnt = 0;
      outstanding = 0;
      ovf_m = 1'b0;
      fifo_m.delete();
      exp_res_q.delete();
      exp_beat_q.push_back(nb);
      return;
    end
    drained = (drain_cnt >= PIPE_LAT);
    idle = drained && (beats_left == 0);
    check("cmd_ready", chk_t'(o_cmd_ready), chk_t'(idle && outstanding < RES_DEPTH));
    check("in_ready", chk_t'(o_in_ready), chk_t'(drained && beats_left > 0));
    check("busy", chk_t'(o_busy), chk_t'(!idle || outstanding != 0));
    check("res_valid", chk_t'(o_res_valid), chk_t'(fifo_m.size() != 0));
    check("res_sum", chk_t'(o_res_sum), chk_t'((fifo_m.size() != 0) ? fifo_m[0] : 16'h0000));
    check("overflow", chk_t'(o_overflow), chk_t'(ovf_m));

    pop = o_res_valid && i_res_ready;
    full = (fifo_m.size() >= RES_DEPTH);
    if (pop) begin
      check("res_pending", chk_t'(exp_res_q.size() > 0), chk_t'(1'b1));
      if (exp_res_q.size() > 0) check("res_order", chk_t'(o_res_sum), chk_t'(exp_res_q.pop_front()));
      if (fifo_m.size() > 0) void'(fifo_m.pop_front());
      outstanding--;
    end
    if (i_valid && drained) begin
      if (!full || pop) fifo_m.push_back(i_sum);
      else ovf_m = 1'b1;
    end
    if (i_cmd_valid && o_cmd_ready) begin
      len = cmd_len_q.pop_front();
      exp_res_q.push_back(cmd_exp_q.pop_front());
      outstanding++;
      if (len == 0) nb = {2'b11, {(2*DW){1'b0}}};
      else begin
        beats_left = len;
        beat_idx = 0;
      end
    end else if (i_in_valid && o_in_ready && beats_left > 0) begin
      nb = {beat_idx == 0, beats_left == 1, beat_a_q.pop_front(), beat_b_q.pop_front()};
      beats_left--;
      beat_idx++;
    end
    if (!drained) drain_cnt++;
    exp_beat_q.push_back(nb);
  endtask

  task automatic run_cycle();
    @(posedge i_clk);
    #1;
    cyc++;
    stack_step();
    drive();
    #1;
    observe();
  endtask

  task automatic settle(input int budget);
    int n = 0;
    while ((cmd_len_q.size() > 0 || beats_left > 0 || outstanding > 0 || pipe_q.size() > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    check("settle_budget", chk_t'(n < budget), chk_t'(1'b1));
  endtask

  initial begin
    int n;
    // Reset for 20 cycles, then a stray stack result during the drain window.
    rst_cycles = 20;
    repeat (20) run_cycle();
    repeat (5) run_cycle();
    spur = 1'b1;
    repeat (15) run_cycle();

    // len=3 with constant lanes 1.0 * 2.0.
    add_cmd(3, 1'b0, 16'h3C00, 16'h4000);
    settle(300);

    // len=4 unstalled, then the same vector with a 2-cycle starve after beat 2.
    add_cmd(4, 1'b0, 16'h3C00, 16'hC000);
    settle(300);
    hold_idx = 2;
    hold_cycles = 2;
    add_cmd(4, 1'b0, 16'h3C00, 16'hC000);
    settle(300);
    hold_idx = -1;

    // len=1 then len=0 back-to-back.
    add_cmd(1, 1'b1, 16'h0000, 16'h0000);
    add_cmd(0, 1'b0, 16'h0000, 16'h0000);
    settle(300);

    // Credit exhaustion with the consumer stalled, then a protocol-violating push into a full FIFO.
    rdy_pct = 0;
    repeat (5) add_cmd(2, 1'b1, 16'h0000, 16'h0000);
    repeat (60) run_cycle();
    spur = 1'b1;
    repeat (2) run_cycle();
    rdy_pct = 100;
    settle(400);

    // Reset while beat 2 of a len=5 vector is being presented.
    add_cmd(5, 1'b1, 16'h0000, 16'h0000);
    n = 0;
    while (beat_idx != 1 && n < 100) begin
      run_cycle();
      n++;
    end
    check("reach_beat2", chk_t'(beat_idx), chk_t'(1));
    rst_cycles = 2;
    repeat (22) run_cycle();
    add_cmd(2, 1'b1, 16'h0000, 16'h0000);
    settle(300);

    // Randomized traffic with starvation and consumer backpressure.
    stall_pct = 30;
    rdy_pct = 60;
    for (int i = 0; i < 40; i++) add_cmd($urandom_range(0, 8), 1'b1, 16'h0000, 16'h0000);
    settle(5000);
    repeat (5) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
